l2_prog_seq: RTL

//  Program sequencer for the lab-2 datapath controller (l2_SM + regfile/ALU).

---
 rtl/l2_prog_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/l2_prog_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l2_prog_seq : program sequencer feeding one instruction at a time to the  |
// |               lab-2 controller. Optional watchdog: L2_SEQ_WDOG_EN.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module l2_prog_seq #(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_we_i,
  input  logic [PC_W-1:0] prog_addr_i,
  input  logic [9:0]      prog_data_i,
  input  logic [PC_W:0]   prog_len_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [3:0]      sm_state_i,
  output logic            execute_o,
  output logic [1:0]      operation_o,
  output logic [1:0]      addr_x_o,
  output logic [1:0]      addr_y_o,
  output logic [3:0]      input_data_o,
  output logic [PC_W-1:0] pc_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [3:0] C_SM_IDLE = 4'b0000;
  localparam logic [3:0] C_SM_DONE = 4'b1000;

  logic [9:0]      mem_q [DEPTH];
  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  logic [9:0]      ir_q, ir_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            w_last;

  // Instruction memory is deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (prog_we_i && (state_q == S_IDLE)) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  assign w_last = ({1'b0, pc_q} == (len_q - {{PC_W{1'b0}}, 1'b1}));

`ifdef L2_SEQ_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            w_wd_state;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (prog_len_i != '0) begin
            len_d   = prog_len_i;
            pc_d    = '0;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else begin
          ir_d    = mem_q[pc_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = abort_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (sm_state_i == C_SM_DONE) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Abort outranks advancing to the next instruction.
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (sm_state_i == C_SM_IDLE) begin
          if (w_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (sm_state_i == C_SM_IDLE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef L2_SEQ_WDOG_EN
    // Counter restarts on every state change; expiring while stuck aborts the run.
    w_wd_state = (state_q == S_WAIT) || (state_q == S_RELEASE) || (state_q == S_DRAIN);
    wd_d       = '0;
    if (w_wd_state && (state_d == state_q)) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef L2_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  // Gating with abort keeps execute from ever rising once an abort is seen.
  assign execute_o    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !abort_i;
  assign operation_o  = ir_q[9:8];
  assign addr_x_o     = ir_q[7:6];
  assign addr_y_o     = ir_q[5:4];
  assign input_data_o = ir_q[3:0];
  assign pc_o         = pc_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire
